// File: rtl/horner_pkg.sv
// Shared encodings for the Horner polynomial sequencer: FSM states and
// the accumulator-mux / add-sub control values driven into the datapath.
package horner_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_X = 3'd1,
        MUL    = 3'd2,
        ACCUM  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] ACC_SEL_COEF = 2'd0;
    localparam logic [1:0] ACC_SEL_SUM  = 2'd1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/horner_wait_counter.sv
// Counts the cycles of a fixed-latency operation; 'last' is high during the
// final cycle of each MUL_LAT-cycle window while enabled.
module horner_wait_counter #(
    parameter int MUL_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic last
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_LAT - 1);

    logic [CNT_W-1:0] cnt;

    // Wraps on the last cycle so back-to-back windows need no explicit clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/horner_sequencer.sv
// Control sequencer that walks a shared multiply/add-sub datapath through
// Horner's rule: reg1 <= c[d], then reg1 <= reg1*x +/- c[i] for i = d-1..0.
module horner_sequencer
    import horner_pkg::*;
#(
    parameter int MAX_DEG = 7,
    parameter int ADDR_W  = 3,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] degree,
    input  logic [MAX_DEG:0]  coef_neg,
    output logic              load_x,
    output logic              load_acc,
    output logic              load_prod,
    output logic [1:0]        acc_sel,
    output logic              op,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MAX_DEG);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] d_lat;
    logic [MAX_DEG:0]  neg_lat;
    logic [ADDR_W-1:0] degree_clamped;
    logic              wait_clear;
    logic              wait_en;
    logic              wait_last;

    assign degree_clamped = (degree > MAX_ADDR) ? MAX_ADDR : degree;

    // The counter is restarted on every entry into MUL.
    assign wait_en    = (state == MUL);
    assign wait_clear = (state == LOAD_X) || ((state == ACCUM) && (idx != '0));

    horner_wait_counter #(
        .MUL_LAT (MUL_LAT)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .clear (wait_clear),
        .en    (wait_en),
        .last  (wait_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            d_lat   <= '0;
            neg_lat <= '0;
        end else if (abort && (state != IDLE)) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        d_lat   <= degree_clamped;
                        neg_lat <= coef_neg;
                        state   <= LOAD_X;
                    end
                end
                LOAD_X: begin
                    if (d_lat == '0) begin
                        state <= DONE;
                    end else begin
                        idx   <= d_lat - ADDR_W'(1);
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (wait_last) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    // idx==0 terminates before any decrement, so idx never wraps.
                    if (idx == '0) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx - ADDR_W'(1);
                        state <= MUL;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        load_x    = 1'b0;
        load_acc  = 1'b0;
        load_prod = 1'b0;
        acc_sel   = ACC_SEL_COEF;
        op        = OP_ADD;
        rom_addr  = '0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            LOAD_X: begin
                load_x   = 1'b1;
                load_acc = 1'b1;
                acc_sel  = ACC_SEL_COEF;
                rom_addr = d_lat;
            end
            MUL: begin
                load_prod = wait_last;
            end
            ACCUM: begin
                load_acc = 1'b1;
                acc_sel  = ACC_SEL_SUM;
                rom_addr = idx;
                op       = neg_lat[idx] ? OP_SUB : OP_ADD;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
